alu_exec_stage: RTL and testbench

Registered execute stage sitting directly downstream of the ALU control unit: it takes the 4-bit ALU operation code plus two operands from the decode/issue side and performs the arithmetic/logic operation. It publishes result, zero flag and writeback tags to the memory/writeback side through a valid/ready handshake. A two-entry skid buffer decouples upstream from downstream stalls without a combinational ready path.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_exec_stage_core.sv | 36 +++
 rtl/alu_exec_stage.sv | 144 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, writeback tag layout, buffer state
// encoding and a code-legality helper. The ALU control unit uses the same codes.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Buffer occupancy. Bit 0 = main register holds an entry, bit 1 = skid
  // register holds an entry, so out_valid and in_ready are plain flop bits.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  // Writeback tag carried alongside each result.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr_en;
  } alu_tag_t;

  function automatic logic alu_code_legal(input logic [3:0] ctl);
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: alu_code_legal = 1'b1;
      default:                                            alu_code_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_stage_core.sv
// Purely combinational ALU. Undefined codes yield result 0 and raise illegal.
module alu_exec_stage_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic slt;

  assign slt = ($signed(op_a) < $signed(op_b));

  // Operation select; ADD/SUB wrap naturally at WIDTH bits.
  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      ALU_NOR: result = ~(op_a | op_b);
      default: result = '0;
    endcase
  end

  assign zero    = (result == '0);
  assign illegal = !alu_code_legal(alu_ctl);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a two-entry skid buffer and a saturating
// retired-operation counter.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no entry buffered, out_valid=0, in_ready=1
// ST_ONE   | main register presented, skid empty
// ST_FULL  | main presented and skid occupied, in_ready=0
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  input  logic             wr_en_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       rd_out,
  output logic             wr_en_out,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    alu_tag_t         tag;
    logic             illegal;
  } entry_t;

  logic [1:0]       state_q, state_d;
  entry_t           main_q, skid_q, new_entry;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, retire;
  logic             load_main, load_skid, move_skid;
  logic [WIDTH-1:0] core_result;
  logic             core_zero, core_illegal;

  alu_exec_stage_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctl (alu_ctl),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (core_result),
    .zero    (core_zero),
    .illegal (core_illegal)
  );

  // An undefined code must never write the register file.
  assign new_entry = '{result:  core_result,
                       zero:    core_zero,
                       tag:     '{rd: rd_in, wr_en: wr_en_in & ~core_illegal},
                       illegal: core_illegal};

  // Both handshake flags come straight from state flop bits.
  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  // Next-state and buffer-movement decode; flush overrides to EMPTY.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (retire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (retire) begin
          move_skid = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // State and buffer registers; payload of a flushed op may land in a
  // register but is never presented because the state goes EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_q <= new_entry;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_entry;
      end
    end
  end

  // Retired-operation counter, saturating at all-ones; retires in a flush
  // cycle still count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign result    = main_q.result;
  assign zero      = main_q.zero;
  assign rd_out    = main_q.tag.rd;
  assign wr_en_out = main_q.tag.wr_en;
  assign illegal   = main_q.illegal;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios followed by random
// traffic, compared against a queue-based model of a two-deep buffer.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        wr_en_in, flush;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  rd_out;
  logic        wr_en_out, illegal;
  logic [3:0]  op_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t       q[$];
  logic [3:0] cnt;

  alu_exec_stage #(.WIDTH(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .wr_en_in  (wr_en_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .rd_out    (rd_out),
    .wr_en_out (wr_en_out),
    .illegal   (illegal),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic we);
    exp_t e;
    e.ill = 1'b0;
    case (ctl)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd6:  e.res = a - b;
      4'd7:  e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd12: e.res = ~(a | b);
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    e.z  = (e.res == 32'd0);
    e.rd = rd;
    e.we = we && !e.ill;
    return e;
  endfunction

  task automatic check_outputs();
    check_val("out_valid", out_valid, q.size() > 0);
    check_val("in_ready", in_ready, q.size() < 2);
    check_val("op_count", op_count, cnt);
    if (q.size() > 0) begin
      check_val("result", result, q[0].res);
      check_val("zero", zero, q[0].z);
      check_val("rd_out", rd_out, q[0].rd);
      check_val("wr_en_out", wr_en_out, q[0].we);
      check_val("illegal", illegal, q[0].ill);
    end
  endtask

  // Called at a falling edge: check, drive, update model, advance one cycle.
  task automatic step(input logic iv, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic we, input logic fl, input logic ordy);
    logic acc, ret;
    check_outputs();
    in_valid  = iv;
    alu_ctl   = ctl;
    op_a      = a;
    op_b      = b;
    rd_in     = rd;
    wr_en_in  = we;
    flush     = fl;
    out_ready = ordy;
    acc = iv && (q.size() < 2);
    ret = (q.size() > 0) && ordy;
    if (ret) begin
      void'(q.pop_front());
      if (cnt != 4'hF) cnt = cnt + 4'd1;
    end
    if (fl) q.delete();
    else if (acc) q.push_back(ref_op(ctl, a, b, rd, we));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    logic [3:0] legal_codes [6];
    legal_codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    cnt = 4'd0;
    rst = 1'b1;
    in_valid = 1'b0; alu_ctl = 4'd0; op_a = 32'd0; op_b = 32'd0;
    rd_in = 5'd0; wr_en_in = 1'b0; flush = 1'b0; out_ready = 1'b0;

    #2;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_result", result, 32'd0);
    check_val("rst_zero", zero, 1'b0);
    check_val("rst_rd_out", rd_out, 5'd0);
    check_val("rst_wr_en_out", wr_en_out, 1'b0);
    check_val("rst_illegal", illegal, 1'b0);
    check_val("rst_op_count", op_count, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic operations, one per cycle with out_ready high.
    step(1'b1, 4'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1);
    check_val("add_result", result, 32'd12);
    check_val("add_zero", zero, 1'b0);
    check_val("add_rd", rd_out, 5'd3);
    step(1'b1, 4'd6, 32'd9, 32'd9, 5'd4, 1'b1, 1'b0, 1'b1);
    check_val("add_op_count", op_count, 4'd1);
    check_val("sub_result", result, 32'd0);
    check_val("sub_zero", zero, 1'b1);
    step(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b1);
    check_val("slt_result", result, 32'd1);
    step(1'b1, 4'd12, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1);
    check_val("nor_result", result, 32'hFFFF_FFFF);
    step(1'b1, 4'd3, 32'd11, 32'd22, 5'd7, 1'b1, 1'b0, 1'b1);
    check_val("ill_illegal", illegal, 1'b1);
    check_val("ill_result", result, 32'd0);
    check_val("ill_wr_en", wr_en_out, 1'b0);
    idle(1'b1);

    // Backpressure: three ops with out_ready low, then drain.
    step(1'b1, 4'd0, 32'hF0F0, 32'hFF00, 5'd8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd1, 32'hF0F0, 32'h0F00, 5'd9, 1'b1, 1'b0, 1'b0);
    check_val("bp_in_ready_full", in_ready, 1'b0);
    step(1'b1, 4'd2, 32'd100, 32'd200, 5'd10, 1'b1, 1'b0, 1'b0);
    check_val("bp_stall_rd", rd_out, 5'd8);
    step(1'b1, 4'd2, 32'd100, 32'd200, 5'd10, 1'b1, 1'b0, 1'b1);
    check_val("bp_second_rd", rd_out, 5'd9);
    step(1'b1, 4'd2, 32'd100, 32'd200, 5'd10, 1'b1, 1'b0, 1'b1);
    check_val("bp_third_rd", rd_out, 5'd10);
    check_val("bp_third_res", result, 32'd300);
    idle(1'b1);

    // Flush while FULL, with an op offered in the same cycle.
    step(1'b1, 4'd2, 32'd1, 32'd1, 5'd12, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 32'd2, 32'd2, 5'd13, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 32'd3, 32'd3, 5'd31, 1'b1, 1'b1, 1'b0);
    check_val("flush_out_valid", out_valid, 1'b0);
    check_val("flush_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Saturation of the retired-op counter.
    for (int i = 0; i < 20; i++)
      step(1'b1, 4'd2, i, 32'd1, 5'(i), 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_val("sat_op_count", op_count, 4'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_codes[$urandom_range(0, 5)];
      step($urandom_range(0, 3) != 0, c, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
           5'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
    end

    // Asynchronous reset between clock edges with entries buffered.
    step(1'b1, 4'd2, 32'd4, 32'd4, 5'd20, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd1, 32'd4, 32'd8, 5'd21, 1'b1, 1'b0, 1'b0);
    check_val("pre_rst_out_valid", out_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    check_val("arst_out_valid", out_valid, 1'b0);
    check_val("arst_in_ready", in_ready, 1'b1);
    check_val("arst_op_count", op_count, 4'd0);
    check_val("arst_result", result, 32'd0);
    check_val("arst_rd_out", rd_out, 5'd0);
    q.delete();
    cnt = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'd6, 32'd50, i, 5'(i + 1), 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
